// File: rtl/clk_div_pkg.sv
// clk_div_pkg: shared FSM state type and default constants for clk_div_gen.
package clk_div_pkg;
    typedef enum logic [1:0] {IDLE, APPLY, SETTLE} state_t;
    localparam int P_NUM_CH      = 4;
    localparam int P_CNT_W       = 16;
    localparam int P_DEF_DIV     = 4;
    localparam int P_LOCK_CYCLES = 16;
endpackage

// File: rtl/clk_div_gen_ch.sv
// clk_div_ch: one divider channel with registered div_out/tick derived from the previous cnt.
module clk_div_ch
    import clk_div_pkg::*;
#(
    parameter int CNT_W   = P_CNT_W,
    parameter int DEF_DIV = P_DEF_DIV
) (
    input  logic             sys_clk,
    input  logic             sys_rst,
    input  logic             load,
    input  logic             sync,
    input  logic [CNT_W-1:0] ld_div,
    input  logic [CNT_W-1:0] ld_phase,
    output logic             div_out,
    output logic             tick
);
    logic [CNT_W-1:0] div_q, div_d, phase_q, phase_d, cnt_q, cnt_d;
    logic div_out_q, div_out_d, tick_q, tick_d;

    assign div_out = div_out_q;
    assign tick    = tick_q;

    always_comb begin
        div_d     = load ? ld_div : div_q;
        phase_d   = load ? ld_phase : phase_q;
        cnt_d     = load ? ld_phase : sync ? phase_q :
                    (div_q == '0 || cnt_q >= div_q - 1'b1) ? '0 : cnt_q + 1'b1;
        // a disabled channel keeps its counter parked at zero
        if (div_d == '0) cnt_d = '0;
        div_out_d = div_q == CNT_W'(1) || cnt_q < (div_q >> 1);
        tick_d    = div_q != '0 && cnt_q == '0;
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            div_q     <= CNT_W'(DEF_DIV);
            phase_q   <= '0;
            cnt_q     <= '0;
            div_out_q <= 1'b0;
            tick_q    <= 1'b0;
        end else begin
            div_q     <= div_d;
            phase_q   <= phase_d;
            cnt_q     <= cnt_d;
            div_out_q <= div_out_d;
            tick_q    <= tick_d;
        end
    end
endmodule

// File: rtl/clk_div_gen.sv
// clk_div_gen: multi-channel clock divider with a validated config handshake and lock tracking.
module clk_div_gen
    import clk_div_pkg::*;
#(
    parameter int NUM_CH      = P_NUM_CH,
    parameter int CNT_W       = P_CNT_W,
    parameter int DEF_DIV     = P_DEF_DIV,
    parameter int LOCK_CYCLES = P_LOCK_CYCLES,
    localparam int CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              sys_clk,
    input  logic              sys_rst,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [CH_W-1:0]   cfg_ch,
    input  logic [CNT_W-1:0]  cfg_div,
    input  logic [CNT_W-1:0]  cfg_phase,
    output logic              cfg_err,
    input  logic              sync,
    output logic [NUM_CH-1:0] div_out,
    output logic [NUM_CH-1:0] tick,
    output logic              locked
);
    localparam int SET_W = $clog2(LOCK_CYCLES + 1);

    state_t state_q, state_d;
    logic [SET_W-1:0] settle_q, settle_d;
    logic [CH_W-1:0] ch_q, ch_d;
    logic [CNT_W-1:0] div_q, div_d, phase_q, phase_d;
    logic err_q, err_d, cfg_bad;

    assign cfg_ready = !sys_rst && state_q == IDLE;
    assign locked    = !sys_rst && state_q != SETTLE;
    assign cfg_err   = err_q;
    assign cfg_bad   = 32'(cfg_ch) >= NUM_CH || (cfg_div != '0 && cfg_phase >= cfg_div);

    always_comb begin
        state_d  = state_q;
        settle_d = settle_q;
        ch_d     = ch_q;
        div_d    = div_q;
        phase_d  = phase_q;
        err_d    = 1'b0;
        if (state_q == IDLE && cfg_valid) begin
            err_d = cfg_bad;
            if (!cfg_bad) begin
                state_d = APPLY;
                ch_d    = cfg_ch;
                div_d   = cfg_div;
                phase_d = cfg_phase;
            end
        end else if (state_q == APPLY) begin
            state_d  = SETTLE;
            settle_d = '0;
        end else if (state_q == SETTLE) begin
            settle_d = settle_q + 1'b1;
            if (settle_q == SET_W'(LOCK_CYCLES - 1)) begin
                state_d  = IDLE;
                settle_d = '0;
            end
        end
    end

    // captured request is cleared on reset so an abandoned APPLY leaves nothing behind
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_q  <= SETTLE;
            settle_q <= '0;
            ch_q     <= '0;
            div_q    <= '0;
            phase_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            settle_q <= settle_d;
            ch_q     <= ch_d;
            div_q    <= div_d;
            phase_q  <= phase_d;
            err_q    <= err_d;
        end
    end

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        clk_div_ch #(.CNT_W(CNT_W), .DEF_DIV(DEF_DIV)) u_ch (
            .sys_clk  (sys_clk),
            .sys_rst  (sys_rst),
            .load     (state_q == APPLY && 32'(ch_q) == c),
            .sync     (sync),
            .ld_div   (div_q),
            .ld_phase (phase_q),
            .div_out  (div_out[c]),
            .tick     (tick[c])
        );
    end
endmodule

// File: tb/tb_clk_div_gen.sv
// tb_clk_div_gen: random and directed stimulus checked every cycle against a behavioural model.
module tb_clk_div_gen;
    localparam int NCH  = 6;
    localparam int CW   = 16;
    localparam int CHW  = 3;
    localparam int LOCK = 16;

    logic sys_clk = 0, sys_rst = 1, cfg_valid = 0, sync = 0, sync_req = 0, rs_en = 0;
    logic [CHW-1:0] cfg_ch = '0;
    logic [CW-1:0] cfg_div = '0, cfg_phase = '0;
    logic cfg_ready, cfg_err, locked;
    logic [NCH-1:0] div_out, tick;

    clk_div_gen #(.NUM_CH(NCH), .CNT_W(CW), .DEF_DIV(4), .LOCK_CYCLES(LOCK)) dut (
        .sys_clk(sys_clk), .sys_rst(sys_rst), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
        .cfg_ch(cfg_ch), .cfg_div(cfg_div), .cfg_phase(cfg_phase), .cfg_err(cfg_err),
        .sync(sync), .div_out(div_out), .tick(tick), .locked(locked)
    );

    always #5 sys_clk = ~sys_clk;

    int checks = 0, failures = 0, err_seen = 0;
    int m_div[NCH], m_phase[NCH], m_cnt[NCH];
    int m_settle = 0, a_ch = 0, a_div = 0, a_ph = 0;
    bit m_apply = 0, chk_en = 0, rdy;
    logic [NCH-1:0] e_dout = '0, e_tick = '0;
    logic e_err = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h t=%0t", nm, act, exp, $time);
        end
    endtask

    // reference: per-channel counters as plain integers, lock as a remaining-cycle count
    always @(posedge sys_clk) begin
        if (sys_rst) begin
            for (int i = 0; i < NCH; i++) begin
                m_div[i] = 4; m_phase[i] = 0; m_cnt[i] = 0;
            end
            e_dout = '0; e_tick = '0; e_err = 0;
            m_apply = 0; m_settle = LOCK; chk_en = 1;
        end else begin
            rdy = !m_apply && m_settle == 0;
            for (int i = 0; i < NCH; i++) begin
                e_dout[i] = m_div[i] == 1 || m_cnt[i] < m_div[i] / 2;
                e_tick[i] = m_div[i] != 0 && m_cnt[i] == 0;
                if (m_apply && i == a_ch) begin
                    m_div[i] = a_div; m_phase[i] = a_ph; m_cnt[i] = a_ph;
                end else if (sync) m_cnt[i] = m_phase[i];
                else if (m_div[i] != 0) m_cnt[i] = (m_cnt[i] + 1) % m_div[i];
                if (m_div[i] == 0) m_cnt[i] = 0;
            end
            if (m_apply) begin
                m_settle = LOCK; m_apply = 0;
            end else if (m_settle > 0) m_settle--;
            e_err = 0;
            if (rdy && cfg_valid) begin
                if (int'(cfg_ch) >= NCH || (cfg_div != 0 && cfg_phase >= cfg_div)) e_err = 1;
                else begin
                    m_apply = 1; a_ch = int'(cfg_ch); a_div = int'(cfg_div); a_ph = int'(cfg_phase);
                end
            end
        end
    end

    always @(negedge sys_clk) if (chk_en) begin
        chk("div_out", 32'(div_out), 32'(e_dout));
        chk("tick", 32'(tick), 32'(e_tick));
        chk("cfg_err", 32'(cfg_err), 32'(e_err));
        chk("cfg_ready", 32'(cfg_ready), 32'(!sys_rst && !m_apply && m_settle == 0));
        chk("locked", 32'(locked), 32'(!sys_rst && m_settle == 0));
        if (cfg_err === 1'b1) err_seen++;
    end

    initial forever begin
        @(negedge sys_clk); #2;
        sync = rs_en ? ($urandom_range(0, 15) == 0) : sync_req;
    end

    task automatic cyc(input int n);
        repeat (n) begin @(negedge sys_clk); #1; end
    endtask

    task automatic wait_ready(output int n);
        n = 0;
        while (cfg_ready !== 1'b1 && n < 200) begin cyc(1); n++; end
        if (n >= 200) chk("ready_timeout", 32'(cfg_ready), 1);
    endtask

    task automatic do_cfg(input int ch, input int dv, input int ph);
        int n;
        wait_ready(n);
        cfg_valid = 1; cfg_ch = CHW'(ch); cfg_div = CW'(dv); cfg_phase = CW'(ph);
        cyc(1);
        cfg_valid = 0;
    endtask

    task automatic measure(input int c, input int len, output int nt, output int nh);
        nt = 0; nh = 0;
        repeat (len) begin nt += int'(tick[c]); nh += int'(div_out[c]); cyc(1); end
    endtask

    initial begin
        int n, nt, nh, e0, ok;
        cyc(3);
        sys_rst = 0;
        wait_ready(n);
        chk("lock_after_reset", n, 16);
        chk("locked_lit", 32'(locked), 1);
        measure(0, 12, nt, nh);
        chk("def_ticks", nt, 3);
        chk("def_high", nh, 6);
        do_cfg(2, 5, 2);
        wait_ready(n);
        chk("busy_cycles", n, 17);
        measure(2, 20, nt, nh);
        chk("ch2_ticks", nt, 4);
        chk("ch2_high", nh, 8);
        e0 = err_seen;
        do_cfg(7, 4, 0);
        do_cfg(3, 3, 3);
        cyc(2);
        chk("err_pulses", err_seen - e0, 2);
        chk("locked_after_rej", 32'(locked), 1);
        do_cfg(0, 1, 0);
        do_cfg(1, 0, 5);
        wait_ready(n);
        ok = 0;
        repeat (10) begin ok += int'(div_out[1:0] == 2'b01 && tick[1:0] == 2'b01); cyc(1); end
        chk("div1_div0", ok, 10);
        for (int i = 0; i < 4; i++) do_cfg(i, 4, i);
        do_cfg(4, 4, 0);
        cyc(3);
        sync_req = 1;
        cyc(1);
        sync_req = 0;
        cyc(1);
        chk("sync_tick", 32'(tick[3:0]), 32'h1);
        chk("sync_dout", 32'(div_out[3:0]), 32'h3);
        wait_ready(n);
        chk("sync_settle", n + 5, 17);
        rs_en = 1;
        repeat (400) begin
            cfg_valid = $urandom_range(0, 3) == 0;
            cfg_ch = CHW'($urandom_range(0, 7));
            cfg_div = CW'($urandom_range(0, 12));
            cfg_phase = CW'($urandom_range(0, 12));
            cyc(1);
        end
        cfg_valid = 0;
        rs_en = 0;
        cyc(2);
        do_cfg(1, 7, 3);
        cyc(5);
        sys_rst = 1;
        cyc(2);
        sys_rst = 0;
        wait_ready(n);
        chk("lock_after_rst2", n, 16);
        measure(1, 16, nt, nh);
        chk("rst_ch1_ticks", nt, 4);
        chk("rst_ch1_high", nh, 8);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
